// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - Pending-load scoreboard with decode stall; optional watchdog via SCOREBOARD_TIMEOUT_EN
module load_scoreboard #(
  parameter int REG_SIZE       = 5,
  parameter int MAX_PENDING    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic                               id_valid,
  input  logic [REG_SIZE-1:0]                id_rs1,
  input  logic [REG_SIZE-1:0]                id_rs2,
  input  logic                               id_useRs1,
  input  logic                               id_useRs2,
  input  logic [REG_SIZE-1:0]                id_rd,
  input  logic                               id_regWrite,
  input  logic                               id_isLoad,
  input  logic                               flush,
  input  logic                               resp_valid,
  input  logic [REG_SIZE-1:0]                resp_rd,
  output logic                               stall,
  output logic [2**REG_SIZE-1:0]             busy_vec,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
  output logic                               timeout_err
);

  localparam int NREG = 2**REG_SIZE;
  localparam int CW   = $clog2(MAX_PENDING+1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);

  logic [NREG-1:0] resp_onehot;
  logic [NREG-1:0] issue_onehot;
  logic [NREG-1:0] eff_busy;
  logic [NREG-1:0] busy_next;
  logic [CW-1:0]   x0_cnt;
  logic            hz1, hz2, waw, full;
  logic            issue, issue_reg, issue_x0;
  logic            resp_reg_ok, resp_x0_ok, resp_ok;

  // One-hot decode of the returning register and of the issuing load's rd
  always_comb begin
    resp_onehot  = '0;
    issue_onehot = '0;
    if (resp_valid) resp_onehot[resp_rd] = 1'b1;
    if (issue_reg)  issue_onehot[id_rd]  = 1'b1;
  end

  // A returning load is visible to hazard checks in its own cycle via the WB forward path
  assign eff_busy = busy_vec & ~resp_onehot;

  // Hazard detection and decode stall
  always_comb begin
    hz1   = id_useRs1   & (id_rs1 != '0) & eff_busy[id_rs1];
    hz2   = id_useRs2   & (id_rs2 != '0) & eff_busy[id_rs2];
    waw   = id_regWrite & (id_rd  != '0) & eff_busy[id_rd];
    full  = id_isLoad & (pending_cnt == MAX_CNT) & ~resp_valid;
    stall = id_valid & ~flush & (hz1 | hz2 | waw | full);
  end

  // Issue and response qualification; responses with nothing outstanding are dropped
  always_comb begin
    issue       = id_valid & ~flush & ~stall & id_isLoad & id_regWrite;
    issue_reg   = issue & (id_rd != '0);
    issue_x0    = issue & (id_rd == '0);
    resp_reg_ok = resp_valid & (resp_rd != '0) & busy_vec[resp_rd];
    resp_x0_ok  = resp_valid & (resp_rd == '0) & (x0_cnt != '0);
    resp_ok     = resp_reg_ok | resp_x0_ok;
  end

  // Next busy vector: clear first, then set, so a same-register reissue stays pending
  always_comb begin
    busy_next    = busy_vec;
    if (resp_reg_ok) busy_next = busy_next & ~resp_onehot;
    busy_next    = busy_next | issue_onehot;
    busy_next[0] = 1'b0;
  end

  // Scoreboard state: busy bits, total outstanding count and x0-load count
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy_vec    <= '0;
      pending_cnt <= '0;
      x0_cnt      <= '0;
    end else begin
      busy_vec <= busy_next;
      case ({issue, resp_ok})
        2'b10:   pending_cnt <= pending_cnt + CW'(1);
        2'b01:   pending_cnt <= pending_cnt - CW'(1);
        default: pending_cnt <= pending_cnt;
      endcase
      case ({issue_x0, resp_x0_ok})
        2'b10:   x0_cnt <= x0_cnt + CW'(1);
        2'b01:   x0_cnt <= x0_cnt - CW'(1);
        default: x0_cnt <= x0_cnt;
      endcase
    end
  end

`ifdef SCOREBOARD_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);

  logic [WW-1:0] wd_cnt;
  logic [WW-1:0] wd_next;

  // Watchdog runs only while loads are outstanding and restarts on every accepted response
  always_comb begin
    wd_next = wd_cnt;
    if (resp_ok || pending_cnt == '0) wd_next = '0;
    else if (wd_cnt != WD_MAX)        wd_next = wd_cnt + WW'(1);
  end

  // Saturating watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= wd_next;
      if (wd_next == WD_MAX) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_scoreboard.sv
// tb/tb_load_scoreboard.sv - Self-checking bench for load_scoreboard
module tb_load_scoreboard;

`ifdef SCOREBOARD_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        id_valid, id_useRs1, id_useRs2, id_regWrite, id_isLoad, flush, resp_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, resp_rd;
  logic        stall;
  logic [31:0] busy_vec;
  logic [2:0]  pending_cnt;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  load_scoreboard #(.REG_SIZE(5), .MAX_PENDING(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstN(rstN), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2), .id_rd(id_rd), .id_regWrite(id_regWrite),
    .id_isLoad(id_isLoad), .flush(flush), .resp_valid(resp_valid), .resp_rd(resp_rd),
    .stall(stall), .busy_vec(busy_vec), .pending_cnt(pending_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic [4:0] rd; logic rw; logic ld; logic fl; logic rv; logic [4:0] rrd;
    logic e_stall; logic [31:0] e_busy; logic [2:0] e_cnt;
  } vec_t;

  typedef struct { logic [31:0] busy; logic [2:0] cnt; int idx; } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic logic [31:0] b(input int n);
    return 32'd1 << n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic rw,
                     input logic ld, input logic fl, input logic rv, input logic [4:0] rrd,
                     input logic es, input logic [31:0] eb, input logic [2:0] ec);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd; t.rw = rw;
    t.ld = ld; t.fl = fl; t.rv = rv; t.rrd = rrd; t.e_stall = es; t.e_busy = eb; t.e_cnt = ec;
    vecs.push_back(t);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_useRs1 = 0; id_useRs2 = 0;
    id_rd = 0; id_regWrite = 0; id_isLoad = 0; flush = 0; resp_valid = 0; resp_rd = 0;
  endtask

  // Drive at negedge, check combinational stall, then compare post-edge state from the queue
  task automatic run_vec(input int i);
    exp_t e;
    @(negedge clk);
    id_valid = vecs[i].v; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
    id_useRs1 = vecs[i].u1; id_useRs2 = vecs[i].u2; id_rd = vecs[i].rd;
    id_regWrite = vecs[i].rw; id_isLoad = vecs[i].ld; flush = vecs[i].fl;
    resp_valid = vecs[i].rv; resp_rd = vecs[i].rrd;
    e.busy = vecs[i].e_busy; e.cnt = vecs[i].e_cnt; e.idx = i;
    exp_q.push_back(e);
    #1;
    check($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("vec%0d busy_vec", e.idx), busy_vec, e.busy);
    check($sformatf("vec%0d pending_cnt", e.idx), {29'd0, pending_cnt}, {29'd0, e.cnt});
  endtask

  // Invariants: count bounded by capacity (also catches underflow wrap), x0 never busy
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      check("inv pending_cnt<=MAX", {31'd0, pending_cnt <= 3'd4}, 32'd1);
      check("inv busy_vec[0]", {31'd0, busy_vec[0]}, 32'd0);
    end
  end

  initial begin
    idle_inputs();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy_vec", busy_vec, 32'd0);
    check("reset pending_cnt", {29'd0, pending_cnt}, 32'd0);
    check("reset timeout_err", {31'd0, timeout_err}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    //  v rs1 rs2 u1 u2 rd rw ld fl rv rrd  stall busy                   cnt
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'd0,                  0);  // idle
    add(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0,   0, b(6),                   1);  // lw x6
    add(1, 6, 0, 1, 0,10, 1, 0, 0, 0, 0,   1, b(6),                   1);  // load-use
    add(1, 6, 0, 1, 0,10, 1, 0, 0, 0, 0,   1, b(6),                   1);
    add(1, 6, 0, 1, 0,10, 1, 0, 0, 1, 6,   0, 32'd0,                  0);  // resp frees
    add(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,   0, b(1),                   1);
    add(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0,   0, b(1)|b(2),              2);
    add(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0,   0, b(1)|b(2)|b(3),         3);
    add(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0,   0, b(1)|b(2)|b(3)|b(4),    4);
    add(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,   1, b(1)|b(2)|b(3)|b(4),    4);  // full
    add(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 2,   0, b(1)|b(3)|b(4)|b(7),    4);  // full + resp
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, b(3)|b(4)|b(7),         3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, b(4)|b(7),              2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,   0, b(7),                   1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 32'd0,                  0);
    add(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0,   0, b(9),                   1);  // lw x9
    add(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0,   1, b(9),                   1);  // add x9,x0,x0 WAW
    add(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, b(9),                   2);  // lw x0
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, b(9),                   1);  // x0 resp
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, b(9),                   1);  // spurious x0
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,12,   0, b(9),                   1);  // spurious x12
    add(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,   0, b(5)|b(9),              2);  // lw x5
    add(1, 5, 0, 1, 0,11, 1, 1, 1, 0, 0,   0, b(5)|b(9),              2);  // flushed
    add(1, 5, 0, 1, 0,11, 1, 1, 0, 0, 0,   1, b(5)|b(9),              2);
    add(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 9,   0, b(5)|b(9),              2);  // resp+reissue x9
    add(0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, b(5)|b(9),              2);  // not valid
    add(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0,   1, b(5)|b(9),              2);  // rs2 hazard
    add(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0,   0, b(5)|b(9),              2);  // rs2 unused
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   0, b(9),                   1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 32'd0,                  0);

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // Asynchronous reset mid-operation
    @(negedge clk);
    id_valid = 1; id_rd = 5; id_regWrite = 1; id_isLoad = 1;
    @(posedge clk);
    #1;
    check("midop busy pre-reset", busy_vec, b(5));
    idle_inputs();
    #2;
    rstN = 1'b0;
    #1;
    check("async reset busy_vec", busy_vec, 32'd0);
    check("async reset pending_cnt", {29'd0, pending_cnt}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Watchdog: one load outstanding with no response
    @(negedge clk);
    id_valid = 1; id_rd = 3; id_regWrite = 1; id_isLoad = 1;
    @(posedge clk);
    #1;
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
`ifdef SCOREBOARD_TIMEOUT_EN
      if (i == 6) check("timeout before limit", {31'd0, timeout_err}, 32'd0);
      if (i == 7) check("timeout at limit", {31'd0, timeout_err}, 32'd1);
`else
      if (i == 7) check("timeout tied off", {31'd0, timeout_err}, 32'd0);
`endif
    end
    @(negedge clk);
    resp_valid = 1; resp_rd = 3;
    @(posedge clk);
    #1;
    idle_inputs();
    check("timeout resp clears count", {29'd0, pending_cnt}, 32'd0);
`ifdef SCOREBOARD_TIMEOUT_EN
    check("timeout sticky", {31'd0, timeout_err}, 32'd1);
`else
    check("timeout still off", {31'd0, timeout_err}, 32'd0);
`endif
    @(negedge clk);
    rstN = 1'b0;
    #1;
    check("timeout cleared by reset", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
